// File: rtl/gshare_predictor_pkg.sv
// Shared defaults and helpers for the gshare direction predictor.
`ifndef XLEN
`define XLEN 32
`endif

`ifndef BTB_INDEX_WIDTH
`define BTB_INDEX_WIDTH 6
`endif

package gshare_predictor_pkg;

    localparam int unsigned DEF_XLEN = `XLEN;

    localparam int unsigned DEF_INDEX_WIDTH = `BTB_INDEX_WIDTH;

    localparam int unsigned DEF_CTR_WIDTH = 2;

    // Saturating up/down step for counters up to 4 bits wide.
    function automatic logic [3:0] sat_step(input logic [3:0] ctr,
                                            input logic       taken,
                                            input logic [3:0] ctr_max);
        logic [3:0] r_next;
        r_next = ctr;
        if (taken) begin
            if (ctr != ctr_max) r_next = ctr + 4'd1;
        end else begin
            if (ctr != 4'd0) r_next = ctr - 4'd1;
        end
        return r_next;
    endfunction

endpackage

// File: rtl/bp_history.sv
// Global history register: speculative shift on predicted branches,
// recovery from the snapshot carried with a mispredicted branch.
module bp_history #(
    parameter int unsigned HIST_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  shift_en,
    input  logic                  shift_bit,
    input  logic                  recover_en,
    input  logic [HIST_WIDTH-1:0] recover_ghr,
    input  logic                  recover_bit,
    output logic [HIST_WIDTH-1:0] ghr
);

    logic [HIST_WIDTH-1:0] r_ghr;
    logic [HIST_WIDTH-1:0] w_shifted;
    logic [HIST_WIDTH-1:0] w_recovered;

    generate
        if (HIST_WIDTH == 1) begin : g_w1
            logic w_unused;
            assign w_unused    = ^recover_ghr;
            assign w_shifted   = shift_bit;
            assign w_recovered = recover_bit;
        end else begin : g_wn
            logic w_unused;
            assign w_unused    = recover_ghr[HIST_WIDTH-1];
            assign w_shifted   = {r_ghr[HIST_WIDTH-2:0], shift_bit};
            assign w_recovered = {recover_ghr[HIST_WIDTH-2:0], recover_bit};
        end
    endgenerate

    // Recovery takes priority over a same-cycle speculative shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ghr <= '0;
        end else if (recover_en) begin
            r_ghr <= w_recovered;
        end else if (shift_en) begin
            r_ghr <= w_shifted;
        end
    end

    assign ghr = r_ghr;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PC XOR global history indexes a
// table of saturating counters; resolution trains the table and repairs
// the history on a mispredict.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int unsigned XLEN        = DEF_XLEN,
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned HIST_WIDTH  = DEF_INDEX_WIDTH,
    parameter int unsigned CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int unsigned CTR_INIT    = 2 ** (CTR_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [XLEN-1:0]       pc_if,
    input  logic                  predict_enable,
    input  logic                  spec_enable,
    output logic                  prediction,
    output logic [CTR_WIDTH-1:0]  predict_strength,
    output logic [HIST_WIDTH-1:0] predict_ghr,
    input  logic                  update_enable,
    input  logic                  is_branch,
    input  logic [XLEN-1:0]       pc_update,
    input  logic [HIST_WIDTH-1:0] update_ghr,
    input  logic                  branch_taken,
    input  logic                  mispredict,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned DEPTH   = 2 ** INDEX_WIDTH;
    localparam logic [3:0]  CTR_MAX = 4'((1 << CTR_WIDTH) - 1);

    logic [CTR_WIDTH-1:0]   r_table [DEPTH];
    logic [31:0]            r_branch_count;
    logic [31:0]            r_mispredict_count;

    logic [HIST_WIDTH-1:0]  w_ghr;
    logic [INDEX_WIDTH-1:0] w_ghr_ext;
    logic [INDEX_WIDTH-1:0] w_upd_ghr_ext;
    logic [INDEX_WIDTH-1:0] w_pred_idx;
    logic [INDEX_WIDTH-1:0] w_upd_idx;
    logic [CTR_WIDTH-1:0]   w_strength;
    logic [CTR_WIDTH-1:0]   w_upd_next;
    logic                   w_upd_valid;
    logic                   w_recover;
    logic                   w_unused;

    assign w_unused = ^{pc_if[XLEN-1:INDEX_WIDTH+2], pc_if[1:0],
                        pc_update[XLEN-1:INDEX_WIDTH+2], pc_update[1:0]};

    // Zero-extend both history values to index width before hashing.
    always_comb begin
        w_ghr_ext                      = '0;
        w_ghr_ext[HIST_WIDTH-1:0]      = w_ghr;
        w_upd_ghr_ext                  = '0;
        w_upd_ghr_ext[HIST_WIDTH-1:0]  = update_ghr;
    end

    assign w_pred_idx  = pc_if[INDEX_WIDTH+1:2] ^ w_ghr_ext;
    assign w_upd_idx   = pc_update[INDEX_WIDTH+1:2] ^ w_upd_ghr_ext;
    assign w_upd_valid = update_enable && is_branch;
    assign w_recover   = w_upd_valid && mispredict;

    // Combinational lookup; a same-cycle update is only visible next cycle.
    always_comb begin
        w_strength = '0;
        if (predict_enable) w_strength = r_table[w_pred_idx];
    end

    assign predict_strength = w_strength;
    assign prediction       = w_strength[CTR_WIDTH-1];
    assign predict_ghr      = w_ghr;

    assign w_upd_next = CTR_WIDTH'(sat_step(4'(r_table[w_upd_idx]), branch_taken, CTR_MAX));

    // Pattern table training on qualified resolutions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_table[i] <= CTR_WIDTH'(CTR_INIT);
            end
        end else if (w_upd_valid) begin
            r_table[w_upd_idx] <= w_upd_next;
        end
    end

    // Performance counters, wrapping modulo 2**32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_upd_valid) r_branch_count     <= r_branch_count + 32'd1;
            if (w_recover)   r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    bp_history #(
        .HIST_WIDTH (HIST_WIDTH)
    ) u_history (
        .clk         (clk),
        .reset_n     (reset_n),
        .shift_en    (predict_enable && spec_enable),
        .shift_bit   (prediction),
        .recover_en  (w_recover),
        .recover_ghr (update_ghr),
        .recover_bit (branch_taken),
        .ghr         (w_ghr)
    );

endmodule
